// File: rtl/fsmc_bus_scheduler.sv
// fsmc_bus_scheduler: bridges one-hot FSMC chip selects to four slave ports.
// An access latches the address at cs rise, decides read/write from the
// synchronized strobes, issues a level request to the selected slave, and
// holds read data on module_out until the front end releases cs.
// Optional build macro: FSMC_SCHED_TIMEOUT_EN adds a slave-ack timeout.
module fsmc_bus_scheduler #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cs,
    input  logic [15:0] module_in,
    input  logic        NWE,
    input  logic        NOE,
    output logic [15:0] module_out,
    output logic [15:0] slv_addr,
    output logic [15:0] slv_wdata,
    output logic [3:0]  slv_wr,
    output logic [3:0]  slv_rd,
    input  logic [3:0]  slv_ack,
    input  logic [63:0] slv_rdata,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("fsmc_bus_scheduler: TIMEOUT_CYCLES must be within 2..255");
    end

    typedef enum logic [2:0] {
        IDLE, DECIDE, WR_WAIT, WR_ISSUE, RD_REQ, RD_HOLD
    } state_t;

    state_t      state, state_n;
    logic        nwe_q1, nwe_s, noe_q1, noe_s;
    logic [3:0]  cs_lat;
    logic [1:0]  ch;
    logic        ack_sel;
    logic [15:0] rdata_sel;
    logic        cs_switch;
    logic        start, latch_addr, latch_wdata, load_rd, load_err, err_set;
    logic        tmo;

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        case (v)
            4'b0010: onehot_index = 2'd1;
            4'b0100: onehot_index = 2'd2;
            4'b1000: onehot_index = 2'd3;
            default: onehot_index = 2'd0;
        endcase
    endfunction

    assign ack_sel   = slv_ack[ch];
    assign rdata_sel = slv_rdata[{ch, 4'b0000} +: 16];
    // A different nonzero select while an access is open ends that access.
    assign cs_switch = (cs != 4'b0000) && (cs != cs_lat);

    // Two-flop synchronizers for the raw FSMC strobes (idle high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nwe_q1 <= 1'b1;
            nwe_s  <= 1'b1;
            noe_q1 <= 1'b1;
            noe_s  <= 1'b1;
        end else begin
            nwe_q1 <= NWE;
            nwe_s  <= nwe_q1;
            noe_q1 <= NOE;
            noe_s  <= noe_q1;
        end
    end

`ifdef FSMC_SCHED_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Count cycles an outstanding slave request has waited for its ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= 8'd0;
        end else if ((state == WR_ISSUE || state == RD_REQ) && !ack_sel && !tmo) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= 8'd0;
        end
    end

    assign tmo = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic plus the datapath load strobes for this transition.
    always_comb begin
        state_n     = state;
        start       = 1'b0;
        latch_addr  = 1'b0;
        latch_wdata = 1'b0;
        load_rd     = 1'b0;
        load_err    = 1'b0;
        err_set     = 1'b0;
        case (state)
            IDLE: begin
                if (cs != 4'b0000) begin
                    start = 1'b1;
                    if ($onehot(cs)) begin
                        latch_addr = 1'b1;
                        state_n    = DECIDE;
                    end else begin
                        err_set  = 1'b1;
                        load_err = 1'b1;
                        state_n  = RD_HOLD;
                    end
                end
            end
            DECIDE: begin
                if (cs_switch)          state_n = IDLE;
                else if (!noe_s)        state_n = RD_REQ;
                else if (!nwe_s)        state_n = WR_WAIT;
                else if (cs == 4'b0000) state_n = IDLE;
            end
            WR_WAIT: begin
                if (cs == 4'b0000) begin
                    latch_wdata = 1'b1;
                    state_n     = WR_ISSUE;
                end else if (cs_switch) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            WR_ISSUE: begin
                if (ack_sel) begin
                    state_n = IDLE;
                end else if (tmo) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_REQ: begin
                if (ack_sel) begin
                    load_rd = 1'b1;
                    state_n = RD_HOLD;
                end else if (tmo) begin
                    err_set  = 1'b1;
                    load_err = 1'b1;
                    state_n  = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (cs == 4'b0000 || cs_switch) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Slave requests and busy decode directly from state, so reset drops them at once.
    always_comb begin
        slv_wr = 4'b0000;
        slv_rd = 4'b0000;
        busy   = (state != IDLE);
        if (state == WR_ISSUE) slv_wr = 4'b0001 << ch;
        if (state == RD_REQ)   slv_rd = 4'b0001 << ch;
    end

    // Address/data latches, returned read data and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_lat     <= 4'b0000;
            ch         <= 2'd0;
            slv_addr   <= 16'h0000;
            slv_wdata  <= 16'h0000;
            module_out <= 16'hFFFF;
            err        <= 1'b0;
        end else begin
            if (start)       cs_lat    <= cs;
            if (latch_addr) begin
                slv_addr <= module_in;
                ch       <= onehot_index(cs);
            end
            if (latch_wdata) slv_wdata <= module_in;
            if (load_rd)       module_out <= rdata_sel;
            else if (load_err) module_out <= ERR_DATA;
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule
